// File: rtl/ysyx_22040237_pkg.sv
`default_nettype none
// ysyx_22040237_pkg: shared widths, reset PC, fetch FSM states and FIFO entry layout
// for the multi-cycle IFU (optional misalign check: YSYX_22040237_IFU_MISALIGN_CHK_EN).
package ysyx_22040237_pkg;

  localparam int          REG_WIDTH  = 64;
  localparam int          INST_WIDTH = 32;
  localparam logic [63:0] RESET_PC   = 64'h8000_0000;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_DROP = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [REG_WIDTH-1:0]  pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  misalign;
  } ifu_entry_t;

  // Pick the 32-bit word of a fetched doubleword addressed by pc[2].
  function automatic logic [31:0] sel_half(input logic [63:0] data, input logic upper);
    return upper ? data[63:32] : data[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040237_sync_fifo.sv
`default_nettype none
// ysyx_22040237_sync_fifo: power-of-two synchronous FIFO with flush and occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ysyx_22040237_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != FULL_CNT) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule
`default_nettype wire

// File: rtl/ysyx_22040237_ifu_mc.sv
`default_nettype none
// ysyx_22040237_ifu_mc: multi-cycle fetch unit, one outstanding request, buffered output.
// Define YSYX_22040237_IFU_MISALIGN_CHK_EN to flag misaligned PCs instead of fetching.
module ysyx_22040237_ifu_mc #(
  parameter int                   REG_WIDTH  = ysyx_22040237_pkg::REG_WIDTH,
  parameter int                   INST_WIDTH = ysyx_22040237_pkg::INST_WIDTH,
  parameter int                   BUF_DEPTH  = 2,
  parameter logic [REG_WIDTH-1:0] RESET_PC   = REG_WIDTH'(ysyx_22040237_pkg::RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [REG_WIDTH-1:0]  redirect_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [REG_WIDTH-1:0]  mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [63:0]           mem_resp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_WIDTH-1:0]  out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic                  out_misalign
);

  import ysyx_22040237_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
  localparam int ENTRY_W = REG_WIDTH + INST_WIDTH + 1;
`else
  localparam int ENTRY_W = REG_WIDTH + INST_WIDTH;
`endif

  ifu_state_e            state;
  ifu_state_e            state_nxt;
  logic [REG_WIDTH-1:0]  pc;
  logic [REG_WIDTH-1:0]  pc_nxt;
  logic                  push;
  logic                  pop;
  logic                  empty;
  logic [CW-1:0]         count;
  logic [ENTRY_W-1:0]    push_data;
  logic [ENTRY_W-1:0]    head;
  logic [INST_WIDTH-1:0] entry_inst;
  logic                  has_slot;
  logic                  req_fire;

  // The push slot is reserved before issue, so a response can never meet a full FIFO.
  assign has_slot     = (count < CW'(BUF_DEPTH));
  assign req_fire     = mem_req_valid && mem_req_ready;
  assign mem_req_addr = {pc[REG_WIDTH-1:3], 3'b000};

`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
  logic mis_flag;
  logic mis_flag_nxt;
  logic mis_pc;
  logic entry_mis;

  assign mis_pc        = (pc[1:0] != 2'b00);
  assign mem_req_valid = rst && (state == IFU_REQ) && has_slot && !mis_flag && !mis_pc;
  assign push_data     = {pc, entry_inst, entry_mis};
  assign out_misalign  = head[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_flag <= 1'b0;
    end else begin
      mis_flag <= mis_flag_nxt;
    end
  end
`else
  assign mem_req_valid = rst && (state == IFU_REQ) && has_slot;
  assign push_data     = {pc, entry_inst};
  assign out_misalign  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IFU_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    push       = 1'b0;
    entry_inst = INST_WIDTH'(sel_half(mem_resp_data, pc[2]));
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    entry_mis    = 1'b0;
    mis_flag_nxt = mis_flag;
`endif

    case (state)
      IFU_REQ: begin
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
        // A misaligned pc yields one flagged entry and then parks until redirected.
        if (!mis_flag && mis_pc && has_slot) begin
          push         = 1'b1;
          entry_inst   = '0;
          entry_mis    = 1'b1;
          mis_flag_nxt = 1'b1;
        end else if (req_fire) begin
          state_nxt = IFU_WAIT;
        end
`else
        if (req_fire) begin
          state_nxt = IFU_WAIT;
        end
`endif
      end
      IFU_WAIT: begin
        if (mem_resp_valid) begin
          push      = 1'b1;
          pc_nxt    = pc + REG_WIDTH'(4);
          state_nxt = IFU_REQ;
        end
      end
      IFU_DROP: begin
        if (mem_resp_valid) begin
          state_nxt = IFU_REQ;
        end
      end
      default: begin
        state_nxt = IFU_REQ;
      end
    endcase

    // Redirect wins over everything; an accepted or pending request must drain in DROP.
    if (redirect_valid) begin
      push   = 1'b0;
      pc_nxt = redirect_pc;
`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
      mis_flag_nxt = 1'b0;
`endif
      if (state == IFU_REQ) begin
        state_nxt = req_fire ? IFU_DROP : IFU_REQ;
      end else begin
        state_nxt = mem_resp_valid ? IFU_REQ : IFU_DROP;
      end
    end
  end

  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;
  assign out_pc    = head[ENTRY_W-1 -: REG_WIDTH];
  assign out_inst  = head[ENTRY_W-REG_WIDTH-1 -: INST_WIDTH];

  ysyx_22040237_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .count     (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040237_ifu_mc.sv
`default_nettype none
// tb_ysyx_22040237_ifu_mc: memory model plus in-order fetch-stream scoreboard for the IFU.
module tb_ysyx_22040237_ifu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misalign;

  always #5 clk = ~clk;

  ysyx_22040237_ifu_mc dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_misalign   (out_misalign)
  );

  int errors = 0;
  int checks = 0;

  // Memory model and scoreboard state.
  logic        pend;
  logic [63:0] pend_addr;
  int          pend_lat;
  int          lat_min, lat_max, ready_pct, oready_pct, redir_pct;
  int          force_mode;
  logic [63:0] force_target;
  logic [63:0] exp_pc;
  logic        chk_empty;
  int          cyc, cap_n, req_n;
  logic [63:0] cap_pc   [8];
  logic [31:0] cap_inst [8];
  int          cap_cyc  [8];
  logic [63:0] req_addr [8];

  typedef struct {
    logic [63:0] target;
    logic [63:0] exp_pc0;
    logic [63:0] exp_pc1;
    logic [63:0] exp_addr1;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] dword_at(input logic [63:0] a);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    return {inst_of(b + 64'd4), inst_of(b)};
  endfunction

  // Enter at a negedge; drive inputs, score the coming edge, leave at the next negedge.
  task automatic tick();
    logic        red;
    logic        rfire;
    logic [63:0] tgt;
    mem_resp_valid = pend && (pend_lat == 0);
    mem_resp_data  = mem_resp_valid ? dword_at(pend_addr) : {$urandom, $urandom};
    mem_req_ready  = ($urandom_range(99) < ready_pct);
    out_ready      = ($urandom_range(99) < oready_pct);
    #1;
    rfire = mem_req_valid && mem_req_ready;
    if ($urandom_range(9) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(3));
    else                        tgt = 64'h8000_0000 + 64'(4 * $urandom_range(4095));
    case (force_mode)
      1:       red = pend && !mem_resp_valid;
      2:       red = rfire;
      3:       red = mem_resp_valid;
      4:       red = 1'b1;
      default: red = ($urandom_range(99) < redir_pct);
    endcase
    if (force_mode != 0 && red) begin
      tgt        = force_target;
      force_mode = 0;
    end
    redirect_valid = red;
    redirect_pc    = tgt;

    if (chk_empty) begin
      chk("out_valid_after_redirect", 64'(out_valid), 64'd0);
      chk_empty = 1'b0;
    end
    if (mem_req_valid) begin
      chk("one_outstanding", 64'(pend), 64'd0);
      chk("req_addr_align", 64'(mem_req_addr[2:0]), 64'd0);
    end
    if (out_valid && out_ready && !red) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_inst", 64'(out_inst), 64'(inst_of(exp_pc)));
`ifndef YSYX_22040237_IFU_MISALIGN_CHK_EN
      chk("out_misalign", 64'(out_misalign), 64'd0);
`endif
      if (cap_n < 8) begin
        cap_pc[cap_n]   = out_pc;
        cap_inst[cap_n] = out_inst;
        cap_cyc[cap_n]  = cyc;
      end
      cap_n++;
      exp_pc = exp_pc + 64'd4;
    end
    if (red) begin
      exp_pc    = tgt;
      chk_empty = 1'b1;
      cap_n     = 0;
      req_n     = 0;
    end
    if (mem_resp_valid) pend = 1'b0;
    else if (pend)      pend_lat--;
    if (rfire) begin
      pend      = 1'b1;
      pend_addr = mem_req_addr;
      pend_lat  = int'($urandom_range(lat_max, lat_min));
      if (!red) begin
        if (req_n < 8) req_addr[req_n] = mem_req_addr;
        req_n++;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_caps(input int n, input int budget, input string name);
    for (int i = 0; i < budget && cap_n < n; i++) tick();
    chk(name, 64'(cap_n >= n), 64'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    out_ready      = 1'b0;
    #1;
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_misalign", 64'(out_misalign), 64'd0);
    pend       = 1'b0;
    pend_lat   = 0;
    pend_addr  = '0;
    chk_empty  = 1'b0;
    force_mode = 0;
    exp_pc     = 64'h8000_0000;
    cap_n      = 0;
    req_n      = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    vecs[0] = '{64'h0000_0000_8000_1000, 64'h0000_0000_8000_1000, 64'h0000_0000_8000_1004, 64'h0000_0000_8000_1000};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
    vecs[2] = '{64'h0000_0000_8000_0004, 64'h0000_0000_8000_0004, 64'h0000_0000_8000_0008, 64'h0000_0000_8000_0008};
    vecs[3] = '{64'h0000_0000_8000_0FF8, 64'h0000_0000_8000_0FF8, 64'h0000_0000_8000_0FFC, 64'h0000_0000_8000_0FF8};

    lat_min = 0; lat_max = 0; ready_pct = 100; oready_pct = 100; redir_pct = 0;
    apply_reset();

    // Sequential fetch from reset, one instruction every two cycles.
    wait_caps(3, 20, "seq_timeout");
    for (int i = 0; i < 3; i++) begin
      chk("seq_pc", cap_pc[i], 64'h8000_0000 + 64'(4 * i));
      chk("seq_cycle", 64'(cap_cyc[i]), 64'(2 + 2 * i));
    end

    // Backpressure: only BUF_DEPTH requests go out, then fetch resumes without loss.
    oready_pct = 0;
    force_mode = 4; force_target = 64'h8000_2000;
    tick();
    repeat (12) tick();
    chk("bp_req_count", 64'(req_n), 64'd2);
    chk("bp_req_valid_low", 64'(mem_req_valid), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_head_pc", out_pc, 64'h8000_2000);
    oready_pct = 100;
    wait_caps(4, 40, "bp_resume_timeout");
    chk("bp_resume_pc3", cap_pc[3], 64'h8000_200C);

    // Redirect in WAIT, on a request handshake, and on a response.
    lat_min = 1; lat_max = 1;
    for (int m = 1; m <= 3; m++) begin
      force_mode   = m;
      force_target = 64'h8000_1000 + 64'(m * 32'h1000);
      for (int i = 0; i < 50 && force_mode != 0; i++) tick();
      chk("redir_fired", 64'(force_mode), 64'd0);
      wait_caps(2, 50, "redir_timeout");
      chk("redir_first_pc", cap_pc[0], 64'h8000_1000 + 64'(m * 32'h1000));
    end

    // Redirect table: first two entries and second fetch address, including wrap.
    lat_min = 0; lat_max = 0;
    for (int v = 0; v < 4; v++) begin
      force_mode = 4; force_target = vecs[v].target;
      tick();
      wait_caps(2, 40, "tbl_timeout");
      chk("tbl_pc0", cap_pc[0], vecs[v].exp_pc0);
      chk("tbl_pc1", cap_pc[1], vecs[v].exp_pc1);
      chk("tbl_inst0", 64'(cap_inst[0]), 64'(inst_of(vecs[v].exp_pc0)));
      chk("tbl_inst1", 64'(cap_inst[1]), 64'(inst_of(vecs[v].exp_pc1)));
      chk("tbl_addr1", req_addr[1], vecs[v].exp_addr1);
    end

    // Randomized traffic, with a reset in the middle.
    lat_min = 0; lat_max = 3; ready_pct = 70; oready_pct = 60; redir_pct = 4;
    repeat (300) tick();
    apply_reset();
    repeat (300) tick();

`ifdef YSYX_22040237_IFU_MISALIGN_CHK_EN
    lat_min = 0; lat_max = 0; ready_pct = 100; oready_pct = 0; redir_pct = 0;
    force_mode = 4; force_target = 64'h8000_0002;
    tick();
    repeat (8) tick();
    chk("mis_no_req", 64'(req_n), 64'd0);
    chk("mis_out_valid", 64'(out_valid), 64'd1);
    chk("mis_flag", 64'(out_misalign), 64'd1);
    chk("mis_inst", 64'(out_inst), 64'd0);
    chk("mis_pc", out_pc, 64'h8000_0002);
    oready_pct = 100;
    force_mode = 4; force_target = 64'h8000_0000;
    tick();
    wait_caps(2, 40, "mis_recover_timeout");
    chk("mis_recover_pc", cap_pc[1], 64'h8000_0004);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22040237_ifu_mc.md
# ysyx_22040237_ifu_mc

Multi-cycle instruction fetch unit for the ysyx_22040237 core, replacing the single-cycle combinational fetch path. Keeps its own PC and issues one fetch at a time to instruction memory over a valid/ready request and valid response channel. Buffers fetched instructions in a small FIFO and presents them to decode with a valid/ready handshake. A redirect input from execute flushes in-flight work and restarts fetch at a new PC.

## Interface
- REG_WIDTH, 64, PC and memory address width
- INST_WIDTH, 32, instruction width
- BUF_DEPTH, 2, instruction FIFO entries (power of two, ≥2)
- RESET_PC, 64'h8000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  REG_WIDTH  new fetch PC
- mem_req_valid  out  1  fetch request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  REG_WIDTH  fetch address, 8-byte aligned (pc with [2:0] cleared)
- mem_resp_valid  in  1  read data returned (always accepted)
- mem_resp_data  in  64  read doubleword
- out_valid  out  1  instruction available
- out_ready  in  1  decode consumes
- out_pc  out  REG_WIDTH  PC of head instruction
- out_inst  out  INST_WIDTH  head instruction
- out_misalign  out  1  head entry from misaligned PC (macro only; otherwise tied 0)

## Operation
- Reset values: pc=RESET_PC, FSM=REQ, FIFO empty, mem_req_valid=0, out_valid=0, out_pc=0, out_inst=0, out_misalign=0.
- FSM states: REQ, WAIT, DROP. At most one request outstanding.
- REQ: mem_req_valid=1 iff FIFO count < BUF_DEPTH. On handshake (valid & ready) → WAIT; pc unchanged.
- WAIT: mem_req_valid=0. On mem_resp_valid: push {pc, inst}, where inst = pc[2] ? data[63:32] : data[31:0]; pc ← pc+4 (wraps modulo 2^REG_WIDTH); → REQ.
- DROP: mem_req_valid=0. On mem_resp_valid: discard data, push nothing; → REQ.
- Redirect (highest priority, any state): FIFO cleared; pc ← redirect_pc; next state:
  - REQ with no handshake this cycle → REQ; the unaccepted request is withdrawn and mem_req_addr follows the new pc.
  - REQ with handshake this cycle → DROP.
  - WAIT without resp this cycle → DROP.
  - WAIT with resp this cycle → REQ; the resp is discarded.
  - DROP with resp → REQ; without resp → DROP.
- FIFO: out_valid = !empty; head drives out_pc/out_inst; pop on out_valid & out_ready. Push and pop in the same cycle are allowed, including when full. Redirect overrides a same-cycle pop and push.
- The push slot is reserved before issue (count < BUF_DEPTH), so a response never arrives while the FIFO is full.

## Timing
- First mem_req_valid in the first clock edge after rst deasserts.
- Response to output: entry pushed at the resp edge; out_valid high the following cycle.
- Peak throughput with 1-cycle memory: one instruction per 2 cycles (REQ→WAIT→REQ).
- Redirect: out_valid=0 in the cycle after the redirect; first request to redirect_pc issued that cycle if in REQ. Otherwise it is issued after the stale response drains.
- Reset asserted mid-operation: all state returns to reset values immediately. A pending memory response arriving after rst deasserts is a system-level error outside this block.

## Configuration
- YSYX_22040237_IFU_MISALIGN_CHK_EN defined:
  - pc[1:0]≠0 at issue sets a misaligned flag; no memory request is made.
  - One entry is pushed with inst=0 and out_misalign=1, then the FSM stays in REQ and issues nothing until a redirect.
- Undefined: pc[1:0] is ignored (address still aligned to 8 bytes), out_misalign is tied 0, and no extra state is added.

## Structure
- Shared package ysyx_22040237_pkg: REG_WIDTH, INST_WIDTH, RESET_PC defaults, FSM state enum, FIFO entry struct {pc, inst, misalign}.
- Sub-module ysyx_22040237_sync_fifo (parametrised width/depth, flush, count output). The FSM and pc register live in the top.

## Test plan
- Reset then memory with 1-cycle latency returning sequential instructions → out_pc 0x80000000, 0x80000004, 0x80000008 with the correct 32-bit halves; one instruction per 2 cycles.
- Hold out_ready=0 → after BUF_DEPTH entries mem_req_valid stays 0; raise out_ready → fetch resumes, no loss or duplicate.
- Redirect to 0x80001000 while in WAIT → stale resp dropped; next out_pc=0x80001000.
- Redirect in the same cycle as a request handshake, and in the same cycle as a resp → both stale data dropped; no stale PC appears at the output.
- pc=0xFFFF_FFFF_FFFF_FFFC → next fetch address 0x0 (wrap).
- Macro defined: redirect to 0x80000002 → one entry with out_misalign=1, no memory request; redirect to 0x80000000 → normal fetch.
